// File: rtl/div_iter.sv
// Radix-2 restoring iterative divider for the Execute stage.
// Produces {remainder, quotient} with MIPS DIV/DIVU semantics and a one-cycle ready pulse.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0]    quo_q, quo_d;
  logic [WIDTH-1:0]    div_q, div_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]  result_q, result_d;

  logic [WIDTH:0]      rem_sh;
  logic [WIDTH:0]      trial;
  logic                opa_neg;
  logic                opb_neg;

  // Two's-complement negate when requested; the most negative value maps onto itself.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign opa_neg = signed_div & opa[WIDTH-1];
  assign opb_neg = signed_div & opb[WIDTH-1];

  // The invariant rem < divisor keeps the trial difference inside WIDTH+1 signed bits.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, div_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        if (start && !annul) begin
          if (opb == '0) begin
            state_d  = DONE;
            result_d = {opa, {WIDTH{1'b1}}};
          end else begin
            state_d   = BUSY;
            div_d     = cond_neg(opb, opb_neg);
            quo_d     = cond_neg(opa, opa_neg);
            rem_d     = '0;
            cnt_d     = '0;
            neg_quo_d = opa_neg ^ opb_neg;
            neg_rem_d = opa_neg;
          end
        end
      end
      BUSY: begin
        if (annul) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          state_d  = DONE;
          result_d = {cond_neg(rem_q, neg_rem_q), cond_neg(quo_q, neg_quo_q)};
        end else begin
          // Dividend bits shift out of quo into rem while quotient bits shift in at LSB.
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign result = result_q;
  assign ready  = (state_q == DONE);
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_div_iter.sv
// Randomized and directed checks of div_iter against an arithmetic reference model.
module tb_div_iter;

  localparam int W = 32;

  logic           clk;
  logic           resetn;
  logic           start;
  logic           signed_div;
  logic           annul;
  logic [W-1:0]   opa;
  logic [W-1:0]   opb;
  logic [2*W-1:0] result;
  logic           ready;
  logic           busy;

  int checks = 0;
  int errors = 0;

  div_iter #(.WIDTH(W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .opa        (opa),
    .opb        (opb),
    .result     (result),
    .ready      (ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // MIPS DIV/DIVU: quotient truncates toward zero, remainder takes the dividend's sign.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sd);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sd) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called one time unit after a rising edge with the DUT in IDLE.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sd, input bit hold_start, input bit scramble);
    int n;
    logic [63:0] exp;
    exp = model(a, b, sd);
    opa = a;
    opb = b;
    signed_div = sd;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    if (scramble) begin
      opa = $urandom;
      opb = $urandom;
      signed_div = ~sd;
    end
    check({tag, ".busy"}, 64'(busy), 64'd1);
    n = 0;
    while (!ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check({tag, ".lat"}, 64'(n), (b == 32'd0) ? 64'd0 : 64'(W + 1));
    check({tag, ".res"}, result, exp);
    @(posedge clk); #1;
    check({tag, ".pulse"}, {62'd0, ready, busy}, 64'd0);
  endtask

  initial begin
    int pulses;
    logic [31:0] ra, rb;
    logic        rs;
    resetn = 1'b0;
    start = 1'b0;
    signed_div = 1'b0;
    annul = 1'b0;
    opa = '0;
    opb = '0;
    #12;
    check("rst.out", {result, ready, busy} != '0 ? 64'd1 : 64'd0, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("idle.busy", 64'(busy), 64'd0);

    do_div("u100_7", 32'd100, 32'd7, 1'b0, 1'b1, 1'b0);
    do_div("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0);
    do_div("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    do_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    do_div("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    do_div("z_s", 32'h0000_1234, 32'd0, 1'b1, 1'b0, 1'b0);
    do_div("z_u", 32'h0000_1234, 32'd0, 1'b0, 1'b0, 1'b0);
    do_div("scr", 32'd1000, 32'd33, 1'b0, 1'b0, 1'b1);

    // annul with start in IDLE blocks acceptance
    start = 1'b1;
    annul = 1'b1;
    opa = 32'd9;
    opb = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    annul = 1'b0;
    check("annul_idle.busy", 64'(busy), 64'd0);

    // annul in BUSY cycle 10: result keeps the previous value, no ready pulse
    opa = 32'h0012_3456;
    opb = 32'h0000_0056;
    signed_div = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    check("annul.busy", 64'(busy), 64'd0);
    check("annul.res", result, model(32'd1000, 32'd33, 1'b0));
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    check("annul.pulses", 64'(pulses), 64'd0);
    do_div("restart", 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);

    // asynchronous reset between edges while BUSY
    opa = 32'd5000;
    opb = 32'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #3 resetn = 1'b0;
    #1;
    check("arst.out", {result, ready, busy} != '0 ? 64'd1 : 64'd0, 64'd0);
    #2 resetn = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready || busy) pulses++;
    end
    check("arst.quiet", 64'(pulses), 64'd0);
    check("arst.res", result, 64'd0);

    // randomized operands, with periodic zero-divisor and overflow corners
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case (i % 8)
        1: rb = rb & 32'h0000_00FF;
        3: rb = 32'd0;
        5: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        7: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      do_div($sformatf("rnd%0d", i), ra, rb, rs, 1'b0, (i % 2) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
